// File: rtl/pipe_stage_skid_reg.sv
// Reusable valid/ready pipeline stage register with synchronous flush and an optional
// two-entry skid buffer that registers the upstream ready.
module pipe_stage_skid_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned SKID   = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic [CTRL_W-1:0] IN_CTRL,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [CTRL_W-1:0] OUT_CTRL,
  output logic [1:0]        OCCUPANCY
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              in_ready_q, in_ready_d;

  logic out_valid, out_xfer, in_xfer;

  always_comb begin
    // A flushed stage never presents its contents downstream.
    out_valid = main_valid_q & ~FLUSH;
    out_xfer  = out_valid & OUT_READY;
    if (SKID != 0) begin
      IN_READY = ~RESET & in_ready_q;
    end else begin
      IN_READY = ~RESET & (OUT_READY | ~main_valid_q);
    end
    in_xfer = IN_VALID & IN_READY;
  end

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;

    if (RESET) begin
      main_valid_d = 1'b0;
      main_data_d  = '0;
      main_ctrl_d  = '0;
      skid_valid_d = 1'b0;
      skid_data_d  = '0;
      skid_ctrl_d  = '0;
    end else if (FLUSH) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (SKID != 0) begin
      if (!main_valid_q || out_xfer) begin
        if (skid_valid_q) begin
          main_valid_d = 1'b1;
          main_data_d  = skid_data_q;
          main_ctrl_d  = skid_ctrl_q;
          skid_valid_d = in_xfer;
          if (in_xfer) begin
            skid_data_d = IN_DATA;
            skid_ctrl_d = IN_CTRL;
          end
        end else if (in_xfer) begin
          main_valid_d = 1'b1;
          main_data_d  = IN_DATA;
          main_ctrl_d  = IN_CTRL;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (in_xfer) begin
        // Main is stalled: park the bundle so upstream ready can stay registered.
        skid_valid_d = 1'b1;
        skid_data_d  = IN_DATA;
        skid_ctrl_d  = IN_CTRL;
      end
    end else begin
      if (in_xfer) begin
        main_valid_d = 1'b1;
        main_data_d  = IN_DATA;
        main_ctrl_d  = IN_CTRL;
      end else if (out_xfer) begin
        main_valid_d = 1'b0;
      end
    end

    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge CLK) begin
    main_valid_q <= main_valid_d;
    main_data_q  <= main_data_d;
    main_ctrl_q  <= main_ctrl_d;
    skid_valid_q <= skid_valid_d;
    skid_data_q  <= skid_data_d;
    skid_ctrl_q  <= skid_ctrl_d;
    in_ready_q   <= in_ready_d;
  end

  assign OUT_VALID = out_valid;
  assign OUT_DATA  = main_data_q;
  assign OUT_CTRL  = main_ctrl_q & {CTRL_W{out_valid}};
  assign OCCUPANCY = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: SKID=1 and SKID=0 instances share stimulus and are each
// compared every cycle against a queue-based model of the stage.
module tb_pipe_stage_skid_reg;

  logic        CLK;
  logic        rst, flush, iv, ordy;
  logic [31:0] idata;
  logic [7:0]  ictrl;

  logic        rdy1, vld1, rdy0, vld0;
  logic [31:0] dat1, dat0;
  logic [7:0]  ctl1, ctl0;
  logic [1:0]  occ1, occ0;

  pipe_stage_skid_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1)) u_skid1 (
    .CLK(CLK), .RESET(rst), .FLUSH(flush), .IN_VALID(iv), .IN_READY(rdy1), .IN_DATA(idata),
    .IN_CTRL(ictrl), .OUT_VALID(vld1), .OUT_READY(ordy), .OUT_DATA(dat1), .OUT_CTRL(ctl1),
    .OCCUPANCY(occ1)
  );

  pipe_stage_skid_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0)) u_skid0 (
    .CLK(CLK), .RESET(rst), .FLUSH(flush), .IN_VALID(iv), .IN_READY(rdy0), .IN_DATA(idata),
    .IN_CTRL(ictrl), .OUT_VALID(vld0), .OUT_READY(ordy), .OUT_DATA(dat0), .OUT_CTRL(ctl0),
    .OCCUPANCY(occ0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: each stage is a FIFO of {ctrl,data}; capacity 2 with skid, 1 without.
  logic [39:0] q1[$];
  logic [39:0] q0[$];
  logic [31:0] last1, last0;
  logic        x1_in, x1_out, x0_in, x0_out;
  int          n_checks, n_fail;
  bit          do_chk;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string nm, input int cap, input int sz, input logic [39:0] head,
                           input logic [31:0] last, input logic rdy, input logic vld,
                           input logic [31:0] dat, input logic [7:0] ctl, input logic [1:0] occ,
                           output logic xin, output logic xout);
    logic ev, er;
    ev = (sz > 0) && !flush;
    er = !rst && ((cap == 2) ? (sz < 2) : (ordy || sz == 0));
    if (do_chk) begin
      chk({nm, "_in_ready"}, {39'd0, rdy}, {39'd0, er});
      chk({nm, "_out_valid"}, {39'd0, vld}, {39'd0, ev});
      chk({nm, "_out_data"}, {8'd0, dat}, {8'd0, (sz > 0) ? head[31:0] : last});
      chk({nm, "_out_ctrl"}, {32'd0, ctl}, {32'd0, ev ? head[39:32] : 8'd0});
      chk({nm, "_occupancy"}, {38'd0, occ}, {38'd0, 2'(sz)});
    end
    xin  = iv && er;
    xout = ev && ordy;
  endtask

  task automatic drive(input logic r, input logic f, input logic v, input logic [31:0] d,
                       input logic [7:0] c, input logic o);
    logic [39:0] h1, h0;
    @(negedge CLK);
    rst = r; flush = f; iv = v; idata = d; ictrl = c; ordy = o;
    #1;
    h1 = (q1.size() > 0) ? q1[0] : 40'd0;
    h0 = (q0.size() > 0) ? q0[0] : 40'd0;
    chk_model("s1", 2, q1.size(), h1, last1, rdy1, vld1, dat1, ctl1, occ1, x1_in, x1_out);
    chk_model("s0", 1, q0.size(), h0, last0, rdy0, vld0, dat0, ctl0, occ0, x0_in, x0_out);
  endtask

  task automatic tick();
    logic [39:0] e;
    @(posedge CLK);
    if (rst) begin
      q1.delete(); q0.delete(); last1 = '0; last0 = '0;
    end else if (flush) begin
      q1.delete(); q0.delete();
    end else begin
      if (x1_out) void'(q1.pop_front());
      if (x1_in) q1.push_back({ictrl, idata});
      if (x0_out) void'(q0.pop_front());
      if (x0_in) q0.push_back({ictrl, idata});
    end
    if (q1.size() > 0) begin e = q1[0]; last1 = e[31:0]; end
    if (q0.size() > 0) begin e = q0[0]; last0 = e[31:0]; end
    do_chk = 1'b1;
  endtask

  task automatic step(input logic r, input logic f, input logic v, input logic [31:0] d,
                      input logic [7:0] c, input logic o);
    drive(r, f, v, d, c, o);
    tick();
  endtask

  initial begin
    n_checks = 0; n_fail = 0; do_chk = 1'b0;
    last1 = '0; last0 = '0;
    rst = 1'b1; flush = 1'b0; iv = 1'b1; idata = '0; ictrl = 8'hFF; ordy = 1'b1;

    // Reset held two cycles with a valid, all-ones control bundle offered.
    step(1, 0, 1, 32'h0, 8'hFF, 1);
    drive(1, 0, 1, 32'h0, 8'hFF, 1);
    chk("rst_ready_s1", {39'd0, rdy1}, 40'd0);
    chk("rst_ready_s0", {39'd0, rdy0}, 40'd0);
    tick();
    drive(0, 0, 0, 32'h0, 8'h00, 1);
    chk("rst_valid", {39'd0, vld1}, 40'd0);
    chk("rst_ctrl", {32'd0, ctl1}, 40'd0);
    chk("rst_data", {8'd0, dat1}, 40'd0);
    chk("rst_occ", {38'd0, occ1}, 40'd0);
    chk("rel_ready_s1", {39'd0, rdy1}, 40'd1);
    chk("rel_ready_s0", {39'd0, rdy0}, 40'd1);
    tick();

    // Streaming at one bundle per cycle.
    step(0, 0, 1, 32'h100, 8'h01, 1);
    drive(0, 0, 1, 32'h104, 8'h02, 1);
    chk("stream_d0", {8'd0, dat1}, 40'h100);
    chk("stream_occ0", {38'd0, occ1}, 40'd1);
    tick();
    drive(0, 0, 1, 32'h108, 8'h03, 1);
    chk("stream_d1", {8'd0, dat1}, 40'h104);
    tick();
    drive(0, 0, 0, 32'h0, 8'h00, 1);
    chk("stream_d2", {8'd0, dat1}, 40'h108);
    chk("stream_occ2", {38'd0, occ1}, 40'd1);
    tick();
    step(0, 0, 0, 32'h0, 8'h00, 1);

    // Backpressure fills the skid entry, then drains in order.
    step(0, 0, 1, 32'hA, 8'h03, 1);
    drive(0, 0, 1, 32'hB, 8'h03, 0);
    chk("bp_s0_ready", {39'd0, rdy0}, 40'd0);
    chk("bp_head", {8'd0, dat1}, 40'hA);
    tick();
    drive(0, 0, 1, 32'hC, 8'h03, 0);
    chk("bp_occ", {38'd0, occ1}, 40'd2);
    chk("bp_ready", {39'd0, rdy1}, 40'd0);
    tick();
    step(0, 0, 1, 32'hC, 8'h03, 0);
    drive(0, 0, 1, 32'hC, 8'h03, 1);
    chk("bp_out_a", {8'd0, dat1}, 40'hA);
    tick();
    drive(0, 0, 1, 32'hC, 8'h03, 1);
    chk("bp_out_b", {8'd0, dat1}, 40'hB);
    tick();
    drive(0, 0, 0, 32'h0, 8'h00, 1);
    chk("bp_out_c", {8'd0, dat1}, 40'hC);
    tick();
    step(0, 0, 0, 32'h0, 8'h00, 1);

    // Flush with both entries full and a bundle offered.
    step(0, 0, 1, 32'h11, 8'h81, 0);
    step(0, 0, 1, 32'h22, 8'h82, 0);
    drive(0, 1, 1, 32'hDEAD, 8'hEE, 1);
    chk("fl_occ_before", {38'd0, occ1}, 40'd2);
    chk("fl_valid_s1", {39'd0, vld1}, 40'd0);
    chk("fl_ctrl_s1", {32'd0, ctl1}, 40'd0);
    chk("fl_valid_s0", {39'd0, vld0}, 40'd0);
    tick();
    drive(0, 0, 0, 32'h0, 8'h00, 1);
    chk("fl_occ_after_s1", {38'd0, occ1}, 40'd0);
    chk("fl_occ_after_s0", {38'd0, occ0}, 40'd0);
    tick();
    step(0, 0, 0, 32'h0, 8'h00, 1);

    // Bubbles after a consumed bundle.
    step(0, 0, 1, 32'h77, 8'h5A, 1);
    drive(0, 0, 0, 32'h0, 8'h00, 1);
    chk("bub_ctrl_live", {32'd0, ctl1}, 40'h5A);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 32'h0, 8'h00, 1);
      chk("bub_ctrl", {32'd0, ctl1}, 40'd0);
      chk("bub_data", {8'd0, dat1}, 40'h77);
      tick();
    end

    // Combinational ready of the single-register variant.
    drive(0, 0, 1, 32'h55, 8'h01, 1);
    chk("s0_ready_empty", {39'd0, rdy0}, 40'd1);
    tick();
    drive(0, 0, 1, 32'h56, 8'h02, 1);
    chk("s0_ready_full_go", {39'd0, rdy0}, 40'd1);
    chk("s0_latency", {8'd0, dat0}, 40'h55);
    tick();
    drive(0, 0, 1, 32'h57, 8'h03, 0);
    chk("s0_ready_full_stall", {39'd0, rdy0}, 40'd0);
    tick();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 8'h00, 1);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
           $urandom, 8'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
Parametrised pipeline stage register for the RV32IM pipeline, replacing the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. It carries a generic data bundle and a control bundle between stages. Flow control is a valid/ready handshake rather than a global busy-wait. It also supports synchronous flush (bubble insertion for branch/jump kills) and an optional two-entry skid buffer, so upstream ready is registered and timing paths are cut.

Parameters:
DATA_W, 32, width of the datapath bundle (PC, ALU result, operands, immediate, packed by the instantiating stage)
CTRL_W, 8, width of the control bundle (write enables, mem read/write, WB select); forced to 0 on every bubble
SKID, 1, 1 = two-entry skid buffer with registered IN_READY; 0 = single register with combinational IN_READY

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  synchronous, active-high reset
FLUSH  input  1  synchronous kill of stage contents (branch mispredict/jump)
IN_VALID  input  1  upstream has a valid bundle
IN_READY  output  1  stage can accept a bundle this cycle
IN_DATA  input  DATA_W  upstream data bundle
IN_CTRL  input  CTRL_W  upstream control bundle
OUT_VALID  output  1  stage holds a valid bundle for downstream
OUT_READY  input  1  downstream accepts (replaces BUSYWAIT: OUT_READY = !BUSYWAIT)
OUT_DATA  output  DATA_W  registered data bundle
OUT_CTRL  output  CTRL_W  registered control bundle; 0 whenever OUT_VALID=0
OCCUPANCY  output  2  number of held entries (0..2; max 1 when SKID=0)

Behaviour:
- Reset: RESET is sampled at the rising edge of CLK. Both entries clear, so OUT_VALID=0, OUT_DATA=0, OUT_CTRL=0 and OCCUPANCY=0. IN_READY=0 while RESET=1. There is no asynchronous path and no #delays.
- Transfers: an input transfer happens when IN_VALID&IN_READY. An output transfer happens when OUT_VALID&OUT_READY.
- Latency: an accepted bundle appears on OUT_* on the edge after acceptance (1 cycle). Throughput is 1 bundle/cycle while OUT_READY=1.
- Bubble rule: OUT_CTRL = main_ctrl & {CTRL_W{OUT_VALID}}. OUT_DATA holds its last loaded value when invalid.
- SKID=0:
  - IN_READY = !RESET & (OUT_READY | !main_valid).
  - On input transfer, main loads IN_*. Otherwise, if an output transfer occurs, main_valid clears.
- SKID=1, main + skid entries:
  - IN_READY = !RESET & !skid_valid, driven directly from a flop.
  - If main is empty or an output transfer occurs: main loads from skid if skid_valid (skid empties, and an input transfer that cycle loads into skid). Otherwise main loads from the input if there is an input transfer. Otherwise main_valid clears.
  - If main is full, OUT_READY=0 and an input transfer occurs: the bundle is captured in skid.
  - Ordering is strictly FIFO. No bundle is ever dropped or duplicated.
- OCCUPANCY = main_valid + skid_valid.
- FLUSH:
  - Priority is below RESET and above everything else.
  - OUT_VALID is combinationally masked to 0 during a FLUSH cycle, so no output transfer occurs and OUT_CTRL=0.
  - At the edge, both entries invalidate. Any input transfer in that cycle completes the handshake but its bundle is discarded.
  - IN_READY follows the normal rule during FLUSH.
- Simultaneous input and output transfer with SKID=1 and main full: main takes the next bundle (skid or input) and OCCUPANCY is unchanged.
- Reset mid-stream (any OCCUPANCY): all contents are lost and the next edge gives OCCUPANCY=0.
- IN_DATA/IN_CTRL are sampled only on input transfers. Stalled contents are held bit-exact for any number of cycles.

Test Plan:
- Reset: RESET=1 for 2 cycles with IN_VALID=1, IN_CTRL=8'hFF -> OUT_VALID=0, OUT_CTRL=0, OUT_DATA=0, IN_READY=0, OCCUPANCY=0. After release, IN_READY=1.
- Streaming: SKID=1, OUT_READY=1, push DATA 0x100,0x104,0x108 on consecutive cycles -> same values on OUT_DATA one cycle later each, no gaps, OCCUPANCY stays 1.
- Backpressure: push 0xA,0xB,0xC with OUT_READY=0 from the second cycle -> 0xA held, 0xB in skid, IN_READY=0 after 0xB, OCCUPANCY=2, 0xC not accepted. Release OUT_READY -> 0xA,0xB,0xC emerge in order.
- Flush: OCCUPANCY=2, assert FLUSH with IN_VALID=1 DATA=0xDEAD -> OUT_VALID=0 that cycle, OCCUPANCY=0 next cycle, 0xDEAD never appears.
- Bubble control: IN_VALID=0 for 3 cycles after a bundle with CTRL=8'h5A is consumed -> OUT_CTRL=0 and OUT_DATA holds its last value.
- SKID=0 instance: OUT_READY=0 with main full -> IN_READY=0 in the same cycle. OUT_READY=1 with IN_VALID=1 -> IN_READY=1 combinationally, 1-cycle latency.
